// File: rtl/instr_writer_if.sv
// Instruction-writer bus: instruction handshake in, byte-wide memory write port out.
interface instr_writer_if #(
  parameter int ADDR_W = 10
);
  logic              addr_load;
  logic [ADDR_W-1:0] start_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [63:0]       valC;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] next_addr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output addr_load, start_addr, in_valid, icode, ifun, rA, rB, valC,
    input  in_ready, mem_we, mem_addr, mem_wdata, next_addr, busy, done, err
  );

  modport slave (
    input  addr_load, start_addr, in_valid, icode, ifun, rA, rB, valC,
    output in_ready, mem_we, mem_addr, mem_wdata, next_addr, busy, done, err
  );
endinterface

// File: rtl/instr_writer.sv
// Serialises one Y86-style instruction into instruction memory, one byte per
// cycle, starting at the write pointer. Oversized or invalid instructions are
// rejected without touching memory.
module instr_writer #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input logic           clk,
  input logic           rst_n,
  instr_writer_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [31:0]       MEM_LIMIT = MEM_BYTES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [79:0]       shreg;   // remaining bytes, next one in [7:0]
  logic [3:0]        remain;  // bytes still to write after the current one
  logic              done_q;
  logic              err_q;

  logic [3:0]        len;
  logic [79:0]       packed_bytes;
  logic [31:0]       span;
  logic              reject;
  logic [ADDR_W-1:0] ptr_inc;

  // Encode the incoming instruction: length and little-endian byte image.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    len          = 4'd1;
    packed_bytes = {72'h0, bus.icode, bus.ifun};
    case (bus.icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        len          = 4'd2;
        packed_bytes = {64'h0, bus.rA, bus.rB, bus.icode, bus.ifun};
      end
      4'h7, 4'h8: begin
        len          = 4'd9;
        packed_bytes = {8'h0, bus.valC, bus.icode, bus.ifun};
      end
      4'h3, 4'h4, 4'h5: begin
        len          = 4'd10;
        packed_bytes = {bus.valC, bus.rA, bus.rB, bus.icode, bus.ifun};
      end
      default: ;
    endcase
    span    = 32'(ptr) + 32'(len);
    reject  = (bus.icode > 4'hB) || (span > MEM_LIMIT);
    ptr_inc = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
  end

  // Control FSM and datapath: accept, reject or emit one byte per cycle.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      shreg  <= '0;
      remain <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.addr_load) begin
            ptr <= bus.start_addr;
          end else if (bus.in_valid) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              shreg  <= packed_bytes;
              remain <= len - 4'd1;
              state  <= EMIT;
            end
          end
        end
        EMIT: begin
          ptr   <= ptr_inc;
          shreg <= {8'h00, shreg[79:8]};
          if (remain == 4'd0) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            remain <= remain - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !bus.addr_load;
  assign bus.mem_we    = (state == EMIT);
  assign bus.busy      = (state == EMIT);
  assign bus.mem_addr  = ptr;
  assign bus.next_addr = ptr;
  assign bus.mem_wdata = shreg[7:0];
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_writer.sv
// Directed bench for instr_writer: vector table plus multi-cycle corner sequences.
module tb_instr_writer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instr_writer_if #(.ADDR_W(10)) bus ();

  instr_writer #(.ADDR_W(10), .MEM_BYTES(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Write/pulse monitor, sampled on the falling edge.
  logic [9:0] w_addr [256];
  logic [7:0] w_data [256];
  int w_cnt    = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      w_addr[w_cnt % 256] <= bus.mem_addr;
      w_data[w_cnt % 256] <= bus.mem_wdata;
      w_cnt <= w_cnt + 1;
    end
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.err === 1'b1)  err_cnt  <= err_cnt + 1;
  end

  typedef struct {
    bit          do_load;
    logic [9:0]  start;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    bit          exp_err;
    int          exp_len;
    logic [9:0]  exp_base;
    logic [79:0] exp_bytes;  // byte k in [8k+7:8k]
    logic [9:0]  exp_next;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_addr(input logic [9:0] a);
    bus.addr_load  = 1'b1;
    bus.start_addr = a;
    @(negedge clk);
    bus.addr_load  = 1'b0;
  endtask

  // Presents one instruction for exactly one rising edge; returns on the next falling edge.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, input string name);
    bus.icode    = ic;
    bus.ifun     = fn;
    bus.rA       = ra;
    bus.rB       = rb;
    bus.valC     = vc;
    bus.in_valid = 1'b1;
    #1;
    check({name, " in_ready"}, 80'(bus.in_ready), 80'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Waits (bounded) for done or err, then one more cycle so the monitor has settled.
  task automatic wait_end(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.done === 1'b1 || bus.err === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check({name, " end seen"}, 80'(seen), 80'd1);
    @(negedge clk);
  endtask

  task automatic check_writes(input string name, input int w0, input logic [9:0] base,
                              input logic [79:0] bytes, input int len);
    int got;
    logic [9:0] a;
    got = w_cnt - w0;
    check({name, " write count"}, 80'(got), 80'(len));
    for (int k = 0; k < len && k < got; k++) begin
      a = base + 10'(k);
      check($sformatf("%s addr[%0d]", name, k), 80'(w_addr[(w0 + k) % 256]), 80'(a));
      check($sformatf("%s data[%0d]", name, k), 80'(w_data[(w0 + k) % 256]), 80'(bytes[8*k +: 8]));
    end
  endtask

  initial begin
    int w0, d0, e0;
    bus.addr_load  = 1'b0;
    bus.start_addr = '0;
    bus.in_valid   = 1'b0;
    bus.icode      = '0;
    bus.ifun       = '0;
    bus.rA         = '0;
    bus.rB         = '0;
    bus.valC       = '0;

    //           ld  start   ic    fn    rA    rB    valC                    err len base    bytes                              next
    vec[0]  = '{1, 10'h000, 4'h3, 4'h0, 4'hF, 4'h2, 64'h123,                 0, 10, 10'h000, 80'h0000_0000_0000_0123_F230,     10'h00A};
    vec[1]  = '{0, 10'h000, 4'hC, 4'h0, 4'h0, 4'h0, 64'h0,                   1, 0,  10'h000, 80'h0,                            10'h00A};
    vec[2]  = '{1, 10'h3F8, 4'h3, 4'h0, 4'h1, 4'h2, 64'h55,                  1, 0,  10'h000, 80'h0,                            10'h3F8};
    vec[3]  = '{0, 10'h000, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0,                   0, 2,  10'h3F8, 80'h1220,                         10'h3FA};
    vec[4]  = '{1, 10'h3FE, 4'h6, 4'h0, 4'h3, 4'h4, 64'h0,                   0, 2,  10'h3FE, 80'h3460,                         10'h000};
    vec[5]  = '{1, 10'h3F7, 4'h8, 4'h0, 4'hF, 4'hF, 64'h1122334455667788,    0, 9,  10'h3F7, 80'h00_1122334455667788_80,       10'h000};
    vec[6]  = '{1, 10'h3F7, 4'h5, 4'h0, 4'h1, 4'h2, 64'h0,                   1, 0,  10'h000, 80'h0,                            10'h3F7};
    vec[7]  = '{1, 10'h100, 4'hA, 4'h0, 4'h4, 4'hF, 64'h0,                   0, 2,  10'h100, 80'h4FA0,                         10'h102};
    vec[8]  = '{0, 10'h000, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0,                   0, 1,  10'h102, 80'h10,                           10'h103};
    vec[9]  = '{0, 10'h000, 4'hF, 4'h0, 4'h0, 4'h0, 64'h0,                   1, 0,  10'h000, 80'h0,                            10'h103};
    vec[10] = '{0, 10'h000, 4'h4, 4'h0, 4'h1, 4'h2, 64'hFFEEDDCCBBAA9988,    0, 10, 10'h103, 80'hFFEEDDCCBBAA9988_1240,        10'h10D};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst next_addr", 80'(bus.next_addr), 80'd0);
    check("rst mem_we",    80'(bus.mem_we),    80'd0);
    check("rst busy",      80'(bus.busy),      80'd0);
    check("rst done",      80'(bus.done),      80'd0);
    check("rst err",       80'(bus.err),       80'd0);
    rst_n = 1'b1;
    #1;
    check("rst in_ready",  80'(bus.in_ready),  80'd1);
    @(negedge clk);

    // Table-driven single instructions
    for (int i = 0; i < NV; i++) begin
      if (vec[i].do_load) load_addr(vec[i].start);
      w0 = w_cnt; d0 = done_cnt; e0 = err_cnt;
      send(vec[i].icode, vec[i].ifun, vec[i].ra, vec[i].rb, vec[i].valc, $sformatf("v%0d", i));
      wait_end($sformatf("v%0d", i));
      check($sformatf("v%0d err pulses", i),  80'(err_cnt - e0),  80'(vec[i].exp_err ? 1 : 0));
      check($sformatf("v%0d done pulses", i), 80'(done_cnt - d0), 80'(vec[i].exp_err ? 0 : 1));
      check_writes($sformatf("v%0d", i), w0, vec[i].exp_base, vec[i].exp_bytes, vec[i].exp_len);
      check($sformatf("v%0d next_addr", i), 80'(bus.next_addr), 80'(vec[i].exp_next));
    end

    // Back-to-back: halt then jmp, jmp handed over in the cycle done pulses
    load_addr(10'h000);
    w0 = w_cnt; d0 = done_cnt;
    bus.icode = 4'h0; bus.ifun = 4'h0; bus.rA = 4'h0; bus.rB = 4'h0; bus.valC = 64'h0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.icode = 4'h7; bus.valC = 64'h40;
    @(negedge clk);
    check("b2b done with ready", 80'({bus.done, bus.in_ready}), 80'b11);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_end("b2b");
    check("b2b done pulses", 80'(done_cnt - d0), 80'd2);
    check_writes("b2b", w0, 10'h000, 80'h00_0000_0000_0000_0040_7000, 10);
    check("b2b next_addr", 80'(bus.next_addr), 80'h00A);

    // addr_load ignored while emitting
    load_addr(10'h200);
    w0 = w_cnt;
    send(4'h3, 4'h0, 4'h1, 4'h2, 64'h0807060504030201, "ign");
    bus.addr_load = 1'b1; bus.start_addr = 10'h050;
    #1;
    check("ign in_ready in EMIT", 80'(bus.in_ready), 80'd0);
    @(negedge clk);
    bus.addr_load = 1'b0;
    wait_end("ign");
    check_writes("ign", w0, 10'h200, 80'h0807060504030201_1230, 10);
    check("ign next_addr", 80'(bus.next_addr), 80'h20A);

    // addr_load wins over in_valid in the same cycle
    w0 = w_cnt; d0 = done_cnt; e0 = err_cnt;
    bus.addr_load = 1'b1; bus.start_addr = 10'h300;
    bus.icode = 4'h0; bus.in_valid = 1'b1;
    #1;
    check("prio in_ready", 80'(bus.in_ready), 80'd0);
    @(negedge clk);
    bus.addr_load = 1'b0; bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("prio next_addr", 80'(bus.next_addr), 80'h300);
    check("prio no writes", 80'(w_cnt - w0), 80'd0);
    check("prio no pulses", 80'((done_cnt - d0) + (err_cnt - e0)), 80'd0);

    // Reset in the middle of a 10-byte instruction, after byte 3 is written
    load_addr(10'h000);
    w0 = w_cnt; d0 = done_cnt;
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h123, "arst");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst mem_we async",  80'(bus.mem_we),    80'd0);
    check("arst busy",          80'(bus.busy),      80'd0);
    check("arst next_addr",     80'(bus.next_addr), 80'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst in_ready",      80'(bus.in_ready),  80'd1);
    repeat (3) @(negedge clk);
    check_writes("arst", w0, 10'h000, 80'h0123_F230, 4);
    check("arst no done",       80'(done_cnt - d0), 80'd0);
    check("arst next_addr end", 80'(bus.next_addr), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
